spike_rate_decoder: RTL

Output-side decoder for the SNN robot controller: counts spikes on the excitatory-neuron output lines (left/right) over a fixed window of enabled cycles, converts them into per-channel spike rates and a registered steering command, and hands the rates to the motor/host side over a valid/ready interface. It performs the inverse of the input neurons' value-to-spike encoding. It sits directly after the top-level SNN's output spike bus.

---
 rtl/spike_rate_decoder.sv | 111 +++++++++++
 1 files changed

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed spike-rate decoder with valid/ready rate output and steering command
// Optional SPIKE_DEC_HYST_EN: command must repeat in two consecutive windows before cmd changes.
module spike_rate_decoder #(
  parameter int EXCNUM   = 2,
  parameter int WINDOW   = 256,
  parameter int CNT_W    = 9,
  parameter int MIN_RATE = 4,
  parameter int MARGIN   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [EXCNUM-1:0]       spike_in,
  output logic [EXCNUM*CNT_W-1:0] rate_data,
  output logic                    rate_valid,
  input  logic                    rate_ready,
  output logic [1:0]              cmd,
  output logic [7:0]              drop_cnt
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   MIN_V    = (CNT_W + 1)'(MIN_RATE);
  localparam logic [CNT_W:0]   MARGIN_V = (CNT_W + 1)'(MARGIN);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] count      [EXCNUM];
  logic [CNT_W-1:0] count_next [EXCNUM];
  logic             active;
  logic             snap;
  logic [CNT_W:0]   l_ext, r_ext;
  logic [1:0]       cmd_eval;
`ifdef SPIKE_DEC_HYST_EN
  logic [1:0]       cand;
`endif

  always_comb begin
    state_next = state;
    active     = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next = RUN;
          active     = 1'b1;
        end
      end
      RUN:     active = en;
      default: state_next = IDLE;
    endcase
  end

  assign snap = active && (win_cnt == WIN_LAST);

  // Counts including this cycle's spikes; the snapshot loads these directly.
  always_comb begin
    for (int i = 0; i < EXCNUM; i++) begin
      count_next[i] = count[i];
      if (spike_in[i] && (count[i] != CNT_MAX)) count_next[i] = count[i] + 1'b1;
    end
  end

  assign l_ext = {1'b0, count_next[0]};
  assign r_ext = {1'b0, count_next[1]};

  always_comb begin
    cmd_eval = 2'b11;
    if ((l_ext < MIN_V) && (r_ext < MIN_V)) cmd_eval = 2'b00;
    else if (l_ext >= r_ext + MARGIN_V)     cmd_eval = 2'b01;
    else if (r_ext >= l_ext + MARGIN_V)     cmd_eval = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      win_cnt    <= '0;
      rate_data  <= '0;
      rate_valid <= 1'b0;
      cmd        <= 2'b00;
      drop_cnt   <= 8'd0;
      for (int i = 0; i < EXCNUM; i++) count[i] <= '0;
`ifdef SPIKE_DEC_HYST_EN
      cand       <= 2'b00;
`endif
    end else begin
      state <= state_next;
      if (active) begin
        win_cnt <= snap ? '0 : win_cnt + 1'b1;
        for (int i = 0; i < EXCNUM; i++) count[i] <= snap ? '0 : count_next[i];
      end
      if (snap) begin
        for (int i = 0; i < EXCNUM; i++) rate_data[i*CNT_W +: CNT_W] <= count_next[i];
        rate_valid <= 1'b1;
        // A same-cycle transfer consumes the old result, so only a stalled one is dropped.
        if (rate_valid && !rate_ready && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
`ifdef SPIKE_DEC_HYST_EN
        if (cmd_eval == cand) cmd  <= cmd_eval;
        else                  cand <= cmd_eval;
`else
        cmd <= cmd_eval;
`endif
      end else if (rate_valid && rate_ready) begin
        rate_valid <= 1'b0;
      end
    end
  end

endmodule
